// File: rtl/quad_pkg.sv
// Shared opcode and FSM state encodings plus default response bytes for the
// flight-controller command path.
package quad_pkg;

    typedef enum logic [7:0] {
        OpReqBatt  = 8'h01,
        OpSetPtch  = 8'h02,
        OpSetRoll  = 8'h03,
        OpSetYaw   = 8'h04,
        OpSetThrst = 8'h05,
        OpCalibrate = 8'h06,
        OpEmerLand = 8'h07,
        OpMtrsOff  = 8'h08
    } opcode_e;

    typedef enum logic [2:0] {
        StIdle,
        StWaitCnv,
        StSpinUp,
        StWaitCal,
        StWaitSent
    } cmd_state_e;

    localparam logic [7:0] AckDefault = 8'hA5;
    localparam logic [7:0] NakDefault = 8'hEE;

    localparam int unsigned SpinCntWidth = 26;

endpackage

// File: rtl/spinup_tmr.sv
// ESC spin-up timer: saturating 26-bit counter with terminal-count flag.
// FAST_SIM_EN shortens the terminal count to 2^9 clocks for simulation.
module spinup_tmr
    import quad_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

`ifdef FAST_SIM_EN
    localparam logic [SpinCntWidth-1:0] TermCnt = SpinCntWidth'(1 << 9);
`else
    localparam logic [SpinCntWidth-1:0] TermCnt = SpinCntWidth'(1 << 25);
`endif

    logic [SpinCntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flag on the last counted cycle so the FSM's registered strt_cal lands
    // exactly TermCnt clocks after entering spin-up.
    assign tc_o = (cnt_q == TermCnt - 1'b1);

endmodule

// File: rtl/cmd_cfg.sv
// Command decoder/configuration FSM between the UART command wrapper and the
// flight controller. Spin-up length depends on FAST_SIM_EN (see spinup_tmr).
module cmd_cfg
    import quad_pkg::*;
#(
    parameter logic [7:0] ACK_VAL = AckDefault,
    parameter logic [7:0] NAK_VAL = NakDefault
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    output logic        clr_cmd_rdy,
    output logic [7:0]  resp,
    output logic        send_resp,
    input  logic        resp_sent,
    output logic        strt_cnv,
    input  logic        cnv_cmplt,
    input  logic [7:0]  batt,
    output logic        strt_cal,
    output logic        inertial_cal,
    input  logic        cal_done,
    output logic [15:0] d_ptch,
    output logic [15:0] d_roll,
    output logic [15:0] d_yaw,
    output logic [8:0]  thrst,
    output logic        motors_off
);

    cmd_state_e  state_q, state_d;
    logic [15:0] d_ptch_q, d_ptch_d, d_roll_q, d_roll_d, d_yaw_q, d_yaw_d;
    logic [8:0]  thrst_q, thrst_d;
    logic [7:0]  resp_q, resp_d;
    logic        motors_off_q, motors_off_d;
    logic        inertial_cal_q, inertial_cal_d;
    logic        send_resp_q, send_resp_d;
    logic        strt_cnv_q, strt_cnv_d;
    logic        strt_cal_q, strt_cal_d;
    logic        tmr_tc;

    spinup_tmr u_spinup_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q == StSpinUp),
        .clr_i ((state_q != StSpinUp) || tmr_tc),
        .tc_o  (tmr_tc)
    );

    always_comb begin
        state_d        = state_q;
        d_ptch_d       = d_ptch_q;
        d_roll_d       = d_roll_q;
        d_yaw_d        = d_yaw_q;
        thrst_d        = thrst_q;
        resp_d         = resp_q;
        motors_off_d   = motors_off_q;
        inertial_cal_d = inertial_cal_q;
        send_resp_d    = 1'b0;
        strt_cnv_d     = 1'b0;
        strt_cal_d     = 1'b0;
        clr_cmd_rdy    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    send_resp_d = 1'b1;
                    resp_d      = ACK_VAL;
                    state_d     = StWaitSent;
                    case (cmd)
                        OpReqBatt: begin
                            send_resp_d = 1'b0;
                            resp_d      = resp_q;
                            strt_cnv_d  = 1'b1;
                            state_d     = StWaitCnv;
                        end
                        OpSetPtch:  d_ptch_d = data;
                        OpSetRoll:  d_roll_d = data;
                        OpSetYaw:   d_yaw_d  = data;
                        OpSetThrst: thrst_d  = data[8:0];
                        OpCalibrate: begin
                            send_resp_d    = 1'b0;
                            resp_d         = resp_q;
                            motors_off_d   = 1'b0;
                            inertial_cal_d = 1'b1;
                            d_ptch_d       = '0;
                            d_roll_d       = '0;
                            d_yaw_d        = '0;
                            thrst_d        = '0;
                            state_d        = StSpinUp;
                        end
                        OpEmerLand: begin
                            d_ptch_d = '0;
                            d_roll_d = '0;
                            d_yaw_d  = '0;
                            thrst_d  = '0;
                        end
                        OpMtrsOff: motors_off_d = 1'b1;
                        default:   resp_d = NAK_VAL;
                    endcase
                end
            end
            StWaitCnv: begin
                if (cnv_cmplt) begin
                    resp_d      = batt;
                    send_resp_d = 1'b1;
                    state_d     = StWaitSent;
                end
            end
            StSpinUp: begin
                if (tmr_tc) begin
                    strt_cal_d = 1'b1;
                    state_d    = StWaitCal;
                end
            end
            StWaitCal: begin
                if (cal_done) begin
                    inertial_cal_d = 1'b0;
                    resp_d         = ACK_VAL;
                    send_resp_d    = 1'b1;
                    state_d        = StWaitSent;
                end
            end
            StWaitSent: begin
                if (resp_sent) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            d_ptch_q       <= '0;
            d_roll_q       <= '0;
            d_yaw_q        <= '0;
            thrst_q        <= '0;
            resp_q         <= '0;
            motors_off_q   <= 1'b1;
            inertial_cal_q <= 1'b0;
            send_resp_q    <= 1'b0;
            strt_cnv_q     <= 1'b0;
            strt_cal_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            d_ptch_q       <= d_ptch_d;
            d_roll_q       <= d_roll_d;
            d_yaw_q        <= d_yaw_d;
            thrst_q        <= thrst_d;
            resp_q         <= resp_d;
            motors_off_q   <= motors_off_d;
            inertial_cal_q <= inertial_cal_d;
            send_resp_q    <= send_resp_d;
            strt_cnv_q     <= strt_cnv_d;
            strt_cal_q     <= strt_cal_d;
        end
    end

    assign d_ptch       = d_ptch_q;
    assign d_roll       = d_roll_q;
    assign d_yaw        = d_yaw_q;
    assign thrst        = thrst_q;
    assign resp         = resp_q;
    assign motors_off   = motors_off_q;
    assign inertial_cal = inertial_cal_q;
    assign send_resp    = send_resp_q;
    assign strt_cnv     = strt_cnv_q;
    assign strt_cal     = strt_cal_q;

endmodule

// File: tb/tb_cmd_cfg.sv
// Directed bench for cmd_cfg: a table of single-command transactions plus
// hand-written battery, calibration and reset sequences.
module tb_cmd_cfg;
    import quad_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic        strt_cnv;
    logic        cnv_cmplt;
    logic [7:0]  batt;
    logic        strt_cal;
    logic        inertial_cal;
    logic        cal_done;
    logic [15:0] d_ptch, d_roll, d_yaw;
    logic [8:0]  thrst;
    logic        motors_off;

    cmd_cfg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_rdy      (cmd_rdy),
        .cmd          (cmd),
        .data         (data),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .resp         (resp),
        .send_resp    (send_resp),
        .resp_sent    (resp_sent),
        .strt_cnv     (strt_cnv),
        .cnv_cmplt    (cnv_cmplt),
        .batt         (batt),
        .strt_cal     (strt_cal),
        .inertial_cal (inertial_cal),
        .cal_done     (cal_done),
        .d_ptch       (d_ptch),
        .d_roll       (d_roll),
        .d_yaw        (d_yaw),
        .thrst        (thrst),
        .motors_off   (motors_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Pulse counters, sampled 1 time unit after each falling edge.
    int clr_cnt  = 0;
    int send_cnt = 0;
    int cnv_cnt  = 0;
    int cal_cnt  = 0;

    always begin
        @(negedge clk);
        #1;
        if (clr_cmd_rdy) clr_cnt++;
        if (send_resp)   send_cnt++;
        if (strt_cnv)    cnv_cnt++;
        if (strt_cal)    cal_cnt++;
    end

    typedef struct {
        logic [7:0]  op;
        logic [15:0] dat;
        logic [7:0]  exp_resp;
        logic [15:0] exp_ptch;
        logic [15:0] exp_roll;
        logic [15:0] exp_yaw;
        logic [8:0]  exp_thrst;
        logic        exp_moff;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present a command in IDLE; returns at the falling edge after acceptance.
    task automatic send_cmd(input logic [7:0] op, input logic [15:0] d);
        cmd_rdy = 1'b1;
        cmd     = op;
        data    = d;
        #1;
        chk("clr_same_cycle", {31'b0, clr_cmd_rdy}, 32'd1);
        @(negedge clk);
        cmd_rdy = 1'b0;
    endtask

    task automatic expect_resp(input string name, input logic [7:0] exp);
        chk({name, "_send"}, {31'b0, send_resp}, 32'd1);
        chk({name, "_resp"}, {24'b0, resp}, {24'b0, exp});
        @(negedge clk);
        chk({name, "_send_1cyc"}, {31'b0, send_resp}, 32'd0);
        chk({name, "_resp_hold"}, {24'b0, resp}, {24'b0, exp});
    endtask

    task automatic resp_done();
        resp_sent = 1'b1;
        @(negedge clk);
        resp_sent = 1'b0;
    endtask

    int k;
    int clr0, send0, cal0;

    initial begin
        vecs[0] = '{OpSetPtch,   16'h003A, 8'hA5, 16'h003A, 16'h0000, 16'h0000, 9'h000, 1'b1};
        vecs[1] = '{OpSetRoll,   16'h8001, 8'hA5, 16'h003A, 16'h8001, 16'h0000, 9'h000, 1'b1};
        vecs[2] = '{OpSetYaw,    16'h7FFF, 8'hA5, 16'h003A, 16'h8001, 16'h7FFF, 9'h000, 1'b1};
        vecs[3] = '{8'h3F,       16'h1234, 8'hEE, 16'h003A, 16'h8001, 16'h7FFF, 9'h000, 1'b1};
        vecs[4] = '{OpSetThrst,  16'hF1FF, 8'hA5, 16'h003A, 16'h8001, 16'h7FFF, 9'h1FF, 1'b1};
        vecs[5] = '{OpEmerLand,  16'hFFFF, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1};
        vecs[6] = '{OpSetThrst,  16'h0123, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h123, 1'b1};
        vecs[7] = '{8'h00,       16'hFFFF, 8'hEE, 16'h0000, 16'h0000, 16'h0000, 9'h123, 1'b1};
        vecs[8] = '{OpMtrsOff,   16'h0000, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h123, 1'b1};
        vecs[9] = '{OpSetPtch,   16'hFFC0, 8'hA5, 16'hFFC0, 16'h0000, 16'h0000, 9'h123, 1'b1};

        rst_n = 1'b0; cmd_rdy = 1'b0; cmd = '0; data = '0; resp_sent = 1'b0;
        cnv_cmplt = 1'b0; batt = '0; cal_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_motors_off", {31'b0, motors_off}, 32'd1);
        chk("rst_thrst", {23'b0, thrst}, 32'd0);
        chk("rst_ptch", {16'b0, d_ptch}, 32'd0);
        chk("rst_resp", {24'b0, resp}, 32'd0);
        chk("rst_inertial_cal", {31'b0, inertial_cal}, 32'd0);
        chk("rst_pulses", {28'b0, send_resp, strt_cnv, strt_cal, clr_cmd_rdy}, 32'd0);
        rst_n = 1'b1;

        repeat (1000) @(negedge clk);
        chk("idle_no_send", send_cnt, 0);
        chk("idle_motors_off", {31'b0, motors_off}, 32'd1);
        chk("idle_thrst", {23'b0, thrst}, 32'd0);

        foreach (vecs[i]) begin
            clr0 = clr_cnt;
            send_cmd(vecs[i].op, vecs[i].dat);
            chk($sformatf("v%0d_ptch", i), {16'b0, d_ptch}, {16'b0, vecs[i].exp_ptch});
            chk($sformatf("v%0d_roll", i), {16'b0, d_roll}, {16'b0, vecs[i].exp_roll});
            chk($sformatf("v%0d_yaw", i), {16'b0, d_yaw}, {16'b0, vecs[i].exp_yaw});
            chk($sformatf("v%0d_thrst", i), {23'b0, thrst}, {23'b0, vecs[i].exp_thrst});
            chk($sformatf("v%0d_moff", i), {31'b0, motors_off}, {31'b0, vecs[i].exp_moff});
            expect_resp($sformatf("v%0d", i), vecs[i].exp_resp);
            chk($sformatf("v%0d_clr_once", i), clr_cnt - clr0, 1);
            resp_done();
        end

        // Battery request with a second command arriving during the conversion
        clr0 = clr_cnt;
        send_cmd(OpReqBatt, 16'h0000);
        chk("batt_strt_cnv", {31'b0, strt_cnv}, 32'd1);
        chk("batt_no_send", {31'b0, send_resp}, 32'd0);
        @(negedge clk);
        chk("batt_strt_cnv_1cyc", {31'b0, strt_cnv}, 32'd0);
        repeat (2) @(negedge clk);
        cmd_rdy = 1'b1; cmd = OpSetPtch; data = 16'h0055;
        #1;
        chk("batt_cmd_ignored", {31'b0, clr_cmd_rdy}, 32'd0);
        @(negedge clk);
        batt = 8'hC0; cnv_cmplt = 1'b1;
        @(negedge clk);
        cnv_cmplt = 1'b0; batt = 8'h00;
        chk("batt_ptch_hold", {16'b0, d_ptch}, 32'h0000_FFC0);
        expect_resp("batt", 8'hC0);
        repeat (2) @(negedge clk);
        chk("batt_clr_held", clr_cnt - clr0, 1);
        chk("batt_ptch_wait", {16'b0, d_ptch}, 32'h0000_FFC0);
        resp_done();
        #1;
        chk("pend_clr", {31'b0, clr_cmd_rdy}, 32'd1);
        @(negedge clk);
        cmd_rdy = 1'b0;
        chk("pend_ptch", {16'b0, d_ptch}, 32'h0000_0055);
        expect_resp("pend", 8'hA5);
        resp_done();
        chk("batt_cnv_once", cnv_cnt, 1);

        // Calibration from motors-off
        send0 = send_cnt;
        send_cmd(OpCalibrate, 16'h0000);
        chk("cal_moff_low", {31'b0, motors_off}, 32'd0);
        chk("cal_inertial", {31'b0, inertial_cal}, 32'd1);
        chk("cal_setpts_zero", {d_ptch, 7'b0, thrst}, 32'd0);
        chk("cal_no_send", {31'b0, send_resp}, 32'd0);
`ifdef FAST_SIM_EN
        k = 0;
        while (!strt_cal && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("spinup_len", k, 512);
        @(negedge clk);
        chk("strt_cal_1cyc", {31'b0, strt_cal}, 32'd0);
        chk("cal_wait_inertial", {31'b0, inertial_cal}, 32'd1);
        repeat (3) @(negedge clk);
        chk("cal_wait_no_send", send_cnt - send0, 0);
        cal_done = 1'b1;
        @(negedge clk);
        cal_done = 1'b0;
        chk("cal_done_inertial", {31'b0, inertial_cal}, 32'd0);
        expect_resp("cal", 8'hA5);
        chk("strt_cal_once", cal_cnt, 1);
        resp_done();
        send_cmd(OpMtrsOff, 16'h0000);
        chk("moff_after_cal", {31'b0, motors_off}, 32'd1);
        expect_resp("moff", 8'hA5);
        resp_done();
        send_cmd(OpCalibrate, 16'h0000);
        chk("cal2_moff_low", {31'b0, motors_off}, 32'd0);
        repeat (100) @(negedge clk);
`else
        repeat (2000) @(negedge clk);
        chk("spinup_no_early_cal", cal_cnt, 0);
        chk("spinup_inertial", {31'b0, inertial_cal}, 32'd1);
        chk("spinup_no_send", send_cnt - send0, 0);
`endif

        // Reset while spinning up
        cal0  = cal_cnt;
        send0 = send_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_moff", {31'b0, motors_off}, 32'd1);
        chk("mid_rst_inertial", {31'b0, inertial_cal}, 32'd0);
        chk("mid_rst_resp", {24'b0, resp}, 32'd0);
        rst_n = 1'b1;
        repeat (700) @(negedge clk);
        chk("post_rst_no_cal", cal_cnt - cal0, 0);
        chk("post_rst_no_send", send_cnt - send0, 0);
        chk("post_rst_moff", {31'b0, motors_off}, 32'd1);
        send_cmd(OpSetThrst, 16'h0010);
        chk("post_rst_thrst", {23'b0, thrst}, 32'h10);
        chk("post_rst_moff_still", {31'b0, motors_off}, 32'd1);
        expect_resp("post_rst", 8'hA5);
        resp_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cmd_cfg.md
CMD_CFG -- requirements
Module: cmd_cfg

Interface
REQ-001 Parameter ACK_VAL, default 8'hA5, positive-acknowledge response byte.
REQ-002 Parameter NAK_VAL, default 8'hEE, response byte for an unknown opcode.
REQ-003 Ports below; one clock; reset is asynchronous and active-low:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- cmd_rdy  in  1  command frame available from UART wrapper
- cmd  in  8  opcode
- data  in  16  command data
- clr_cmd_rdy  out  1  one-cycle pulse to knock down cmd_rdy
- resp  out  8  response byte
- send_resp  out  1  one-cycle pulse to transmit resp
- resp_sent  in  1  response transmission complete
- strt_cnv  out  1  one-cycle pulse to start battery A2D conversion
- cnv_cmplt  in  1  conversion done
- batt  in  8  battery reading, valid when cnv_cmplt is high
- strt_cal  out  1  one-cycle pulse to start inertial calibration
- inertial_cal  out  1  high while calibration sequence runs
- cal_done  in  1  calibration complete
- d_ptch, d_roll, d_yaw  out  16  signed setpoints
- thrst  out  9  unsigned thrust setpoint
- motors_off  out  1  forces ESCs to idle

Function
REQ-004 Opcodes: 01 REQ_BATT, 02 SET_PTCH, 03 SET_ROLL, 04 SET_YAW, 05 SET_THRST, 06 CALIBRATE, 07 EMER_LAND, 08 MTRS_OFF.
REQ-005 FSM states: IDLE, WAIT_CNV, SPIN_UP, WAIT_CAL, WAIT_SENT.
REQ-006 IDLE with cmd_rdy high: clr_cmd_rdy is pulsed in that same cycle; the opcode is acted on at the next edge.
REQ-007 cmd_rdy outside IDLE is ignored and not cleared; it is serviced on return to IDLE.
REQ-008 SET_PTCH/ROLL/YAW: target register <= data; send_resp pulses with resp=ACK_VAL one cycle after acceptance; next state WAIT_SENT.
REQ-009 SET_THRST: thrst <= data[8:0] (upper bits discarded); acknowledged as in REQ-008.
REQ-010 EMER_LAND: d_ptch, d_roll, d_yaw and thrst <= 0 on the same edge; ACK; motors_off unchanged.
REQ-011 MTRS_OFF: motors_off <= 1; ACK; motors_off stays high until a CALIBRATE command.
REQ-012 REQ_BATT: strt_cnv pulses; WAIT_CNV; on cnv_cmplt, resp <= batt and send_resp pulses; WAIT_SENT.
REQ-013 CALIBRATE: motors_off <= 0, all setpoints <= 0, inertial_cal <= 1, spin-up counter cleared; SPIN_UP.
REQ-014 SPIN_UP: counter increments each clk; at terminal count strt_cal pulses once; WAIT_CAL.
REQ-015 WAIT_CAL: on cal_done, inertial_cal <= 0 and ACK is sent; WAIT_SENT.
REQ-016 Unknown opcode: no register changes; resp=NAK_VAL with send_resp; WAIT_SENT.
REQ-017 WAIT_SENT: return to IDLE on resp_sent; resp holds its value until the next send_resp.
REQ-018 If cnv_cmplt and cmd_rdy are high in the same cycle, the conversion result wins and cmd_rdy is held for IDLE.
REQ-019 The spin-up counter is 26 bits wide, saturates rather than wraps, and is cleared on leaving SPIN_UP.

Reset
REQ-020 Asynchronous reset forces state IDLE, all setpoints 0, resp 0, motors_off 1, inertial_cal 0, all pulse outputs 0, counter 0.
REQ-021 Reset mid-sequence (any state) aborts with no response sent; after release a CALIBRATE is required before the motors run.

Configuration
REQ-022 Macro FAST_SIM_EN defined: spin-up terminal count = 2^9 clocks.
REQ-023 Macro FAST_SIM_EN undefined: terminal count = 2^25 clocks (about 0.67 s at 50 MHz).

Structure
REQ-024 Package quad_pkg holds the opcode enum, the FSM state enum, and the ACK/NAK defaults, shared with the flight-controller blocks and the testbench tasks.
REQ-025 One sub-module, spinup_tmr (counter plus terminal-count compare, FAST_SIM_EN aware); all other logic stays inline.

Verification
REQ-026 Reset then hold cmd_rdy low -> motors_off=1, thrst=0, no send_resp for 1000 cycles.
REQ-027 SET_PTCH data 16'h003A -> d_ptch=16'h003A and resp=8'hA5 one cycle after acceptance; clr_cmd_rdy pulses exactly once.
REQ-028 SET_THRST data 16'hF1FF -> thrst=9'h1FF; then EMER_LAND -> all setpoints 0 and ACK sent.
REQ-029 REQ_BATT with batt=8'hC0 -> strt_cnv pulses once; resp=8'hC0 follows cnv_cmplt; a cmd_rdy raised in WAIT_CNV is serviced only after resp_sent.
REQ-030 MTRS_OFF then CALIBRATE (FAST_SIM_EN) -> motors_off falls, strt_cal occurs 512 cycles later, ACK follows cal_done.
REQ-031 Opcode 8'h3F -> resp=8'hEE and setpoints unchanged; rst_n asserted during SPIN_UP -> no strt_cal, motors_off=1.
